// File: rtl/sec_pkg.sv
// rtl/sec_pkg.sv - shared types and constants for the serial unloader datapath
package sec_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_unloader_if.sv
// rtl/serial_unloader_if.sv - parallel word input and serial bit output handshakes
interface serial_unloader_if
    import sec_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;
    logic             busy;

    modport master (
        output in_valid, data_in, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  in_valid, data_in, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );

endinterface

// File: rtl/serial_unloader.sv
// rtl/serial_unloader.sv - parallel-to-serial unloader, one bit per accepted cycle
module serial_unloader
    import sec_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    serial_unloader_if.slave   bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shift_reg, shift_nxt;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
    logic               last_take;

    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

    assign bus.ser_last  = (state == SHIFT) && (bit_cnt == LAST_CNT);
    assign bus.ser_valid = (state == SHIFT);
    assign bus.busy      = (state == SHIFT);
    assign bus.ser_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

    // Accepting the final bit frees the word slot in the same cycle, so a
    // waiting word can load with no bubble.
    assign last_take    = bus.ser_last && bus.ser_ready;
    assign bus.in_ready = (state == IDLE) || last_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_nxt = bus.data_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_take) begin
                    cnt_nxt = '0;
                    if (bus.in_valid) begin
                        shift_nxt = bus.data_in;
                    end else begin
                        shift_nxt = shifted;
                        state_nxt = IDLE;
                    end
                end else if (bus.ser_ready) begin
                    shift_nxt = shifted;
                    cnt_nxt   = bit_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_unloader.sv
// tb/tb_serial_unloader.sv - directed self-checking bench for serial_unloader
module tb_serial_unloader;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_unloader_if #(.WIDTH(32)) bus_m ();
    serial_unloader_if #(.WIDTH(32)) bus_l ();

    serial_unloader #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    serial_unloader #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    // observation order: {ser_out, ser_valid, ser_last, in_ready, busy}
    localparam logic [4:0] IDLE_OBS = 5'b00010;

    typedef struct {
        logic        in_valid;
        logic [31:0] data;
        logic        ser_ready;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [4:0] obs_m();
        return {bus_m.ser_out, bus_m.ser_valid, bus_m.ser_last, bus_m.in_ready, bus_m.busy};
    endfunction

    function automatic logic [4:0] obs_l();
        return {bus_l.ser_out, bus_l.ser_valid, bus_l.ser_last, bus_l.in_ready, bus_l.busy};
    endfunction

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got out/valid/last/ready/busy=%b expected %b", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Loads d on the MSB-first unit and checks nbits bits, optionally stalling.
    task automatic send_word_m(input string tag, input logic [31:0] d, input int stall_at,
                               input int stall_len, input int nbits);
        logic lst;
        bus_m.in_valid  = 1'b1;
        bus_m.data_in   = d;
        bus_m.ser_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s_load", tag), obs_m(), IDLE_OBS);
        next_cycle();
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            lst = (k == 31);
            if (k == stall_at) begin
                bus_m.ser_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk($sformatf("%s_stall%0d", tag, s), obs_m(), {d[31-k], 1'b1, lst, 1'b0, 1'b1});
                    next_cycle();
                end
                bus_m.ser_ready = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, k), obs_m(), {d[31-k], 1'b1, lst, lst, 1'b1});
            next_cycle();
        end
        if (nbits == 32) begin
            @(negedge clk);
            chk($sformatf("%s_idle", tag), obs_m(), IDLE_OBS);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] dl;
        logic        lst;
        int          b;

        vecs[0] = '{1'b0, 32'h0000_0000, 1'b1, IDLE_OBS};
        vecs[1] = '{1'b1, 32'h8000_0001, 1'b1, IDLE_OBS};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 5'b11001};
        // in_valid during SHIFT (not last bit) must be ignored
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 5'b01001};

        rst             = 1'b1;
        bus_m.in_valid  = 1'b0;
        bus_m.data_in   = '0;
        bus_m.ser_ready = 1'b0;
        bus_l.in_valid  = 1'b0;
        bus_l.data_in   = '0;
        bus_l.ser_ready = 1'b0;

        next_cycle();
        next_cycle();
        chk("reset_msb", obs_m(), IDLE_OBS);
        chk("reset_lsb", obs_l(), IDLE_OBS);
        rst = 1'b0;

        // Table: idle, load 8000_0001, first two bits
        for (int i = 0; i < 4; i++) begin
            bus_m.in_valid  = vecs[i].in_valid;
            bus_m.data_in   = vecs[i].data;
            bus_m.ser_ready = vecs[i].ser_ready;
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs_m(), vecs[i].exp);
            next_cycle();
        end
        bus_m.in_valid = 1'b0;
        w = 32'h8000_0001;
        for (int k = 2; k < 32; k++) begin
            lst = (k == 31);
            @(negedge clk);
            chk($sformatf("single_bit%0d", k), obs_m(), {w[31-k], 1'b1, lst, lst, 1'b1});
            next_cycle();
        end
        @(negedge clk);
        chk("single_idle", obs_m(), IDLE_OBS);
        next_cycle();

        send_word_m("stall", 32'hA5A5_A5A5, 5, 3, 32);
        next_cycle();

        // Back-to-back: two words, continuous valid, in_ready only on last bits
        bus_m.in_valid  = 1'b1;
        bus_m.data_in   = 32'hFFFF_0000;
        bus_m.ser_ready = 1'b1;
        @(negedge clk);
        chk("b2b_load", obs_m(), IDLE_OBS);
        next_cycle();
        bus_m.data_in = 32'h0000_FFFF;
        for (int k = 0; k < 64; k++) begin
            w   = (k < 32) ? 32'hFFFF_0000 : 32'h0000_FFFF;
            b   = k % 32;
            lst = (b == 31);
            if (k == 63) bus_m.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_bit%0d", k), obs_m(), {w[31-b], 1'b1, lst, lst, 1'b1});
            next_cycle();
        end
        @(negedge clk);
        chk("b2b_idle", obs_m(), IDLE_OBS);
        next_cycle();

        // Reset after bit 10, then a clean word
        send_word_m("partial", 32'hDEAD_BEEF, 99, 0, 11);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", obs_m(), IDLE_OBS);
        next_cycle();
        send_word_m("after_rst", 32'h8000_0001, 99, 0, 32);
        next_cycle();

        // LSB-first unit
        dl              = 32'h0000_0003;
        bus_l.in_valid  = 1'b1;
        bus_l.data_in   = dl;
        bus_l.ser_ready = 1'b1;
        @(negedge clk);
        chk("lsb_load", obs_l(), IDLE_OBS);
        next_cycle();
        bus_l.in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            lst = (k == 31);
            @(negedge clk);
            chk($sformatf("lsb_bit%0d", k), obs_l(), {dl[k], 1'b1, lst, lst, 1'b1});
            next_cycle();
        end
        @(negedge clk);
        chk("lsb_idle", obs_l(), IDLE_OBS);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_unloader.md
# serial_unloader

Parallel-to-serial unloader for the 32-bit datapath. It accepts one parallel word per valid/ready handshake and emits its bits one per accepted cycle on a serial stream with its own valid/ready/last handshake. It sits downstream of the team's enabled 32-bit registers and converts their contents into a bit stream for serial links and bench monitors.

## Interface
Parameters:
- WIDTH, 32, parallel word width, minimum 2
- MSB_FIRST, 1, 1 shifts data_in[WIDTH-1] out first, 0 shifts data_in[0] out first

Ports:
- clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high
- rst  input  1  synchronous active-high reset, sampled on rising clk
- in_valid  input  1  parallel word offered
- in_ready  output  1  unloader accepts a word this cycle
- data_in  input  WIDTH  parallel word, sampled when in_valid && in_ready
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out holds a valid bit
- ser_last  output  1  current bit is the final bit of the word
- ser_ready  input  1  downstream accepts the current bit
- busy  output  1  a word is held (state SHIFT)

## Operation
- State machine with two states:
  - IDLE: ser_valid=0. in_ready=1. When in_valid=1, the block captures data_in into shift_reg, clears bit_cnt, and moves to SHIFT.
  - SHIFT: ser_valid=1 and busy=1. When ser_ready=1, the block shifts shift_reg by one toward the output end and increments bit_cnt.
- ser_out selects the bit: shift_reg[WIDTH-1] when MSB_FIRST=1, otherwise shift_reg[0]. Vacated bits fill with 0.
- bit_cnt is $clog2(WIDTH) bits wide. ser_last = (state==SHIFT) && (bit_cnt==WIDTH-1).
- Last bit accepted (ser_last && ser_ready):
  - If in_valid=1, the block loads the new word, clears bit_cnt, and stays in SHIFT. This is back-to-back operation with no bubble.
  - Otherwise it moves to IDLE.
- in_ready = (state==IDLE) || (ser_last && ser_ready). This output is combinational from ser_ready.
- Stall: while ser_ready=0, ser_out, ser_last, shift_reg and bit_cnt hold.
- in_valid is ignored in SHIFT, except on the cycle the last bit is accepted.
- Reset values: state=IDLE, shift_reg=0, bit_cnt=0. Outputs during reset: ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1.
- Reset mid-word: the partial word is discarded and no further bits are emitted. The cycle after rst deasserts is IDLE.
- rst has priority over all handshakes in the same cycle.

## Timing
- Load at edge N. The first bit is valid in the cycle after edge N; latency is 1 clock.
- With ser_ready held at 1, a word occupies exactly WIDTH consecutive cycles of ser_valid.
- Back-to-back words with in_valid held at 1 give continuous ser_valid and one ser_last every WIDTH cycles.
- Throughput is 1 bit/clk. All outputs except in_ready are registered or decoded from registered state.

## Structure
- Shared package sec_pkg holds:
  - the state typedef (enum {IDLE, SHIFT})
  - the default word width constant DATA_W=32, reused by the register and this block
- The block is a single module. It has no sub-modules; the counter and shifter are inline.

## Test plan
- Reset then idle: hold rst=1 for 2 cycles, then release. Required: in_ready=1, ser_valid=0, busy=0, ser_out=0.
- Single word, MSB_FIRST=1, data_in=32'h8000_0001, ser_ready=1:
  - bit stream is 1, thirty 0s, 1
  - ser_last high only on the 32nd bit
  - IDLE the following cycle
- Stall: send 32'hA5A5_A5A5 and drop ser_ready for 3 cycles after bit 5. Required: bit 5 value and ser_last are held. Stream resumes with bit 6 and there is no lost or duplicated bit.
- Back-to-back: send 32'hFFFF_0000 then 32'h0000_FFFF with in_valid=1 throughout. Required: 64 contiguous valid bits, two ser_last pulses 32 cycles apart, and in_ready pulsing only on those last-bit cycles.
- Reset mid-word and LSB-first:
  - rst asserted after bit 10: ser_valid=0 the next cycle, and the next word starts cleanly from bit 0.
  - With MSB_FIRST=0 and data_in=32'h0000_0003, the first two bits out are 1, 1, then thirty 0s.
